splat_writer: RTL and testbench
===============================

Name: splat_writer

Overview:
- Packs one 2D splat (screen-space fields) into four 64-bit little-endian words of the 32-byte splat_2d_t record and streams them to the DDR3 write path.
- Generates sequential word addresses from a programmable base.
- Sits between the projection/binning stage and the DDR3 write arbiter.
- Is the write-side counterpart of the splat unpacker.

Parameters:
- ADDR_W, 29, width of the 64-bit-word address.
- CNT_W, 20, width of the splat counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: latch base_addr, clear count, enable acceptance
- base_addr  in  ADDR_W  word address of record 0, sampled on start
- in_valid  in  1  splat fields valid
- in_ready  out  1  splat accepted when in_valid && in_ready
- sx_fp  in  32  signed s14.4
- sy_fp  in  32  signed s14.4
- depth  in  32  IEEE float bits, passed through
- cov_a_fp  in  16  u2.14
- cov_c_fp  in  16  u2.14
- cov_b2_fp  in  32  signed s2.14
- r, g, b, opacity  in  8 each  colour/opacity
- bbox_x0, bbox_y0, bbox_x1, bbox_y1  in  16 each  signed pixel bounds
- word_data  out  64  packed word
- word_addr  out  ADDR_W  destination word address
- word_valid  out  1  word_data/word_addr valid
- word_ready  in  1  downstream accepts word
- splat_count  out  CNT_W  splats fully written since start
- busy  out  1  a splat is held or being emitted

Behaviour:
- Reset values: in_ready=0, word_valid=0, word_data=0, word_addr=0, splat_count=0, busy=0; internal active=0, word_idx=0, held=0.
- active is set by start and cleared only by reset. While !active, in_ready=0.
- Holding register: one splat record (all fields).
  - in_ready = active && !start && (!held || (word_valid && word_ready && word_idx==3)).
  - This gives back-to-back splats with zero bubble: 4 words per 4 cycles when word_ready=1.
- Acceptance:
  - On in_valid && in_ready, the fields are registered, held=1, word_idx=0.
  - word_valid rises the next cycle (1-cycle latency from acceptance to first word).
- Packing by word_idx:
  - 0: [31:0]=sx_fp, [63:32]=sy_fp.
  - 1: [31:0]=depth, [47:32]=cov_a_fp, [63:48]=cov_c_fp.
  - 2: [31:0]=cov_b2_fp, [39:32]=r, [47:40]=g, [55:48]=b, [63:56]=opacity.
  - 3: [15:0]=bbox_x0, [31:16]=bbox_y0, [47:32]=bbox_x1, [63:48]=bbox_y1.
- word_valid = held.
- word_addr = base_q + {splat_count,2'b00} + word_idx, computed modulo 2^ADDR_W (wraps silently).
- Output stability: word_data and word_addr stay stable while word_valid && !word_ready.
- Handshake:
  - word_idx advances only on word_valid && word_ready.
  - On acceptance of word 3: splat_count += 1 (wraps mod 2^CNT_W), held=0 unless a new splat is accepted in the same cycle, word_idx=0.
- busy = held.
- start has priority over everything except reset:
  - base_q<=base_addr, splat_count<=0, held<=0, word_idx<=0.
  - Any partially emitted splat is abandoned. Its remaining words are not issued; earlier words already written stay in memory.
  - word_valid is low the cycle after start.
  - in_ready is 0 during the start cycle, so a coincident in_valid is not accepted.
- Reset mid-splat: all state returns to reset values; active=0 until the next start.
- No combinational path from in_valid to word_valid. in_ready depends combinationally on word_ready.

Optional Feature:
- Macro: SPLAT_WRITER_CULL_EN.
- Defined:
  - An accepted splat with bbox_x1<bbox_x0 or bbox_y1<bbox_y0 (signed compare) is dropped. It does not set held and emits no words.
  - A CNT_W output port cull_count increments per drop (wraps); reset and start clear it to 0.
  - splat_count counts written splats only.
- Undefined: every accepted splat is written; the cull_count port does not exist.

Decomposition:
- Package splat_pkg: typedef splat_2d_t (packed struct in word order above), localparam SPLAT_WORDS=4, SPLAT_BYTES=32, field-width constants, function pack_splat_word(splat_2d_t, idx) returning 64 bits.
- Natural sub-module: splat_word_mux (pure combinational 4:1 pack by index), reused by tests and any future packer. The sequential control stays in splat_writer.

Test Plan:
- Reset, start with base_addr=0x100, one splat (sx=0x00000150, sy=0xFFFFFFF0, depth=0x3F800000, cov_a=0x4000, cov_c=0x2000, cov_b2=0xFFFFF000, rgba=11/22/33/FF, bbox=(-2,3,40,50)), word_ready=1 -> four words at addresses 0x100..0x103:
  - 0xFFFFFFF0_00000150
  - 0x2000_4000_3F800000
  - 0xFF332211_FFFFF000
  - 0x0032_0028_0003_FFFE
  - splat_count=1.
- Three splats presented continuously, word_ready=1 -> 12 consecutive word_valid cycles with no bubble; addresses base..base+11; splat_count=3.
- word_ready toggling 1,0,0,1... -> word_data/word_addr held constant while stalled; no word skipped or duplicated; in_ready low until word 3 accepts.
- start asserted after word 1 accepted -> word_valid low next cycle; count=0; the next splat is written at the new base starting word 0.
- Before any start, in_valid=1 -> in_ready=0 and no words. Then base_addr=0x1FFFFFFE and two splats -> addresses wrap 0x1FFFFFFE,0x1FFFFFFF,0x0,0x1...
- With SPLAT_WRITER_CULL_EN, bbox x0=10,x1=5 -> no words emitted, cull_count=1, splat_count unchanged.

Source files
------------

// File: rtl/splat_pkg.sv
// Shared types and packing helper for the 32-byte splat_2d_t record.
// splat_2d_t is laid out LSB-first in word order: bits [63:0] hold word 0.
package splat_pkg;

    localparam int SPLAT_WORDS = 4;
    localparam int SPLAT_BYTES = 32;
    localparam int SPLAT_BITS  = SPLAT_BYTES * 8;
    localparam int WORD_W      = 64;
    localparam int POS_W       = 32;
    localparam int DEPTH_W     = 32;
    localparam int COV_W       = 16;
    localparam int COV_B2_W    = 32;
    localparam int COLOR_W     = 8;
    localparam int BBOX_W      = 16;

    typedef struct packed {
        logic [BBOX_W-1:0]   bbox_y1;
        logic [BBOX_W-1:0]   bbox_x1;
        logic [BBOX_W-1:0]   bbox_y0;
        logic [BBOX_W-1:0]   bbox_x0;
        logic [COLOR_W-1:0]  opacity;
        logic [COLOR_W-1:0]  b;
        logic [COLOR_W-1:0]  g;
        logic [COLOR_W-1:0]  r;
        logic [COV_B2_W-1:0] cov_b2_fp;
        logic [COV_W-1:0]    cov_c_fp;
        logic [COV_W-1:0]    cov_a_fp;
        logic [DEPTH_W-1:0]  depth;
        logic [POS_W-1:0]    sy_fp;
        logic [POS_W-1:0]    sx_fp;
    } splat_2d_t;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_EMIT = 2'd2
    } wr_state_t;

    function automatic logic [WORD_W-1:0] pack_splat_word(splat_2d_t s, logic [1:0] idx);
        logic [WORD_W-1:0] w;
        w = '0;
        case (idx)
            2'd0: w = {s.sy_fp, s.sx_fp};
            2'd1: w = {s.cov_c_fp, s.cov_a_fp, s.depth};
            2'd2: w = {s.opacity, s.b, s.g, s.r, s.cov_b2_fp};
            2'd3: w = {s.bbox_y1, s.bbox_x1, s.bbox_y0, s.bbox_x0};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/splat_word_mux.sv
// Combinational 4:1 selector of one 64-bit word out of a packed splat record.
module splat_word_mux
    import splat_pkg::*;
(
    input  logic [SPLAT_BITS-1:0] rec,
    input  logic [1:0]            idx,
    output logic [WORD_W-1:0]     word
);

    assign word = pack_splat_word(splat_2d_t'(rec), idx);

endmodule

// File: rtl/splat_writer.sv
// Packs one splat into four 64-bit words and streams them with sequential addresses.
// Optional SPLAT_WRITER_CULL_EN drops splats with an inverted bbox and counts them.
//
// state   | meaning
// ST_OFF  | no start seen since reset, nothing accepted
// ST_IDLE | armed, holding register empty
// ST_EMIT | holding register full, words 0..3 being offered
module splat_writer
    import splat_pkg::*;
#(
    parameter int ADDR_W = 29,
    parameter int CNT_W  = 20
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         sx_fp,
    input  logic [31:0]         sy_fp,
    input  logic [31:0]         depth,
    input  logic [15:0]         cov_a_fp,
    input  logic [15:0]         cov_c_fp,
    input  logic [31:0]         cov_b2_fp,
    input  logic [7:0]          r,
    input  logic [7:0]          g,
    input  logic [7:0]          b,
    input  logic [7:0]          opacity,
    input  logic [15:0]         bbox_x0,
    input  logic [15:0]         bbox_y0,
    input  logic [15:0]         bbox_x1,
    input  logic [15:0]         bbox_y1,
    output logic [63:0]         word_data,
    output logic [ADDR_W-1:0]   word_addr,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [CNT_W-1:0]    splat_count,
`ifdef SPLAT_WRITER_CULL_EN
    output logic [CNT_W-1:0]    cull_count,
`endif
    output logic                busy
);

    wr_state_t         state, state_nxt;
    splat_2d_t         rec_q, rec_in;
    logic [1:0]        word_idx;
    logic [ADDR_W-1:0] base_q;
    logic              active, held;
    logic              accept, drop, keep, word_fire, last_fire;

    always_comb begin
        rec_in = '{sx_fp: sx_fp, sy_fp: sy_fp, depth: depth,
                   cov_a_fp: cov_a_fp, cov_c_fp: cov_c_fp, cov_b2_fp: cov_b2_fp,
                   r: r, g: g, b: b, opacity: opacity,
                   bbox_x0: bbox_x0, bbox_y0: bbox_y0, bbox_x1: bbox_x1, bbox_y1: bbox_y1};
    end

    assign active    = (state != ST_OFF);
    assign held      = (state == ST_EMIT);
    assign word_fire = word_valid && word_ready;
    assign last_fire = word_fire && (word_idx == 2'd3);
    assign accept    = in_valid && in_ready;

`ifdef SPLAT_WRITER_CULL_EN
    assign drop = accept && (($signed(bbox_x1) < $signed(bbox_x0)) ||
                             ($signed(bbox_y1) < $signed(bbox_y0)));
`else
    assign drop = 1'b0;
`endif
    assign keep = accept && !drop;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_OFF;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (keep) state_nxt = ST_EMIT;
                ST_EMIT: if (last_fire && !keep) state_nxt = ST_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // in_ready reopens during the last word's handshake so splats stream without a bubble
    always_comb begin
        word_valid = held;
        busy       = held;
        in_ready   = active && !start && (!held || last_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q       <= '0;
            word_idx    <= '0;
            base_q      <= '0;
            splat_count <= '0;
`ifdef SPLAT_WRITER_CULL_EN
            cull_count  <= '0;
`endif
        end else if (start) begin
            base_q      <= base_addr;
            splat_count <= '0;
            word_idx    <= '0;
`ifdef SPLAT_WRITER_CULL_EN
            cull_count  <= '0;
`endif
        end else begin
            if (keep) begin
                rec_q    <= rec_in;
                word_idx <= '0;
            end else if (word_fire) begin
                word_idx <= word_idx + 2'd1;
            end
            if (last_fire) splat_count <= splat_count + CNT_W'(1);
`ifdef SPLAT_WRITER_CULL_EN
            if (drop) cull_count <= cull_count + CNT_W'(1);
`endif
        end
    end

    assign word_addr = base_q + ADDR_W'({splat_count, 2'b00}) + ADDR_W'(word_idx);

    splat_word_mux u_word_mux (
        .rec  (rec_q),
        .idx  (word_idx),
        .word (word_data)
    );

endmodule

// File: tb/tb_splat_writer.sv
// Bench for splat_writer: vector table, directed corner sequences and a random run
// checked against a byte-level model of the 32-byte little-endian record.
module tb_splat_writer;

    localparam int ADDR_W = 29;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       sx_fp = '0, sy_fp = '0, depth = '0, cov_b2_fp = '0;
    logic [15:0]       cov_a_fp = '0, cov_c_fp = '0;
    logic [7:0]        r = '0, g = '0, b = '0, opacity = '0;
    logic [15:0]       bbox_x0 = '0, bbox_y0 = '0, bbox_x1 = '0, bbox_y1 = '0;
    logic [63:0]       word_data;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic [CNT_W-1:0]  splat_count;
    logic              busy;
`ifdef SPLAT_WRITER_CULL_EN
    logic [CNT_W-1:0]  cull_count;
`endif

    always #5 clk = ~clk;

    splat_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .sx_fp(sx_fp), .sy_fp(sy_fp), .depth(depth),
        .cov_a_fp(cov_a_fp), .cov_c_fp(cov_c_fp), .cov_b2_fp(cov_b2_fp),
        .r(r), .g(g), .b(b), .opacity(opacity),
        .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
        .word_data(word_data), .word_addr(word_addr), .word_valid(word_valid),
        .word_ready(word_ready), .splat_count(splat_count),
`ifdef SPLAT_WRITER_CULL_EN
        .cull_count(cull_count),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [31:0]      sx, sy, dp, cb2;
        logic [15:0]      ca, cc;
        logic [7:0]       cr, cg, cb, op;
        logic [15:0]      x0, y0, x1, y1;
        logic [3:0][63:0] w;
    } vec_t;

    vec_t vecs[4];

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic              m_active = 1'b0;
    logic [ADDR_W-1:0] m_base = '0;
    int                m_n = 0;
    logic [CNT_W-1:0]  m_written = '0;
    logic [CNT_W-1:0]  m_cull = '0;
    logic [63:0]       exp_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    bit                exp_last[$];
    logic [63:0]       obs_data[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic              prev_stall = 1'b0;
    logic [63:0]       prev_data = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int                run_len = 0;
    int                max_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic vec_t mk(input logic [31:0] sx, sy, dp, input logic [15:0] ca, cc,
                                input logic [31:0] cb2, input logic [7:0] cr, cg, cb, op,
                                input logic [15:0] x0, y0, x1, y1,
                                input logic [63:0] w0, w1, w2, w3);
        vec_t v;
        v.sx = sx; v.sy = sy; v.dp = dp; v.ca = ca; v.cc = cc; v.cb2 = cb2;
        v.cr = cr; v.cg = cg; v.cb = cb; v.op = op;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        return v;
    endfunction

    function automatic vec_t cur_vec();
        vec_t v;
        v.sx = sx_fp; v.sy = sy_fp; v.dp = depth; v.ca = cov_a_fp; v.cc = cov_c_fp;
        v.cb2 = cov_b2_fp; v.cr = r; v.cg = g; v.cb = b; v.op = opacity;
        v.x0 = bbox_x0; v.y0 = bbox_y0; v.x1 = bbox_x1; v.y1 = bbox_y1;
        v.w = '0;
        return v;
    endfunction

    // builds the 32-byte record byte by byte, then reads word k back little-endian
    function automatic logic [63:0] ref_word(input vec_t v, input int k);
        logic [7:0]  mem [32];
        logic [63:0] w;
        for (int i = 0; i < 4; i++) begin
            mem[i]      = v.sx[8*i +: 8];
            mem[4 + i]  = v.sy[8*i +: 8];
            mem[8 + i]  = v.dp[8*i +: 8];
            mem[16 + i] = v.cb2[8*i +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            mem[12 + i] = v.ca[8*i +: 8];
            mem[14 + i] = v.cc[8*i +: 8];
            mem[24 + i] = v.x0[8*i +: 8];
            mem[26 + i] = v.y0[8*i +: 8];
            mem[28 + i] = v.x1[8*i +: 8];
            mem[30 + i] = v.y1[8*i +: 8];
        end
        mem[20] = v.cr; mem[21] = v.cg; mem[22] = v.cb; mem[23] = v.op;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem[8*k + i];
        return w;
    endfunction

    function automatic bit is_culled(input vec_t v);
`ifdef SPLAT_WRITER_CULL_EN
        return ($signed(v.x1) < $signed(v.x0)) || ($signed(v.y1) < $signed(v.y0));
`else
        return 1'b0;
`endif
    endfunction

    // monitor and model, sampled mid-cycle
    always @(negedge clk) begin
        vec_t v;
        logic exp_ir;
        chk("splat_count", 64'(splat_count), 64'(m_written));
        chk("word_valid", 64'(word_valid), 64'(exp_data.size() != 0));
        chk("busy", 64'(busy), 64'(exp_data.size() != 0));
        exp_ir = m_active && !start &&
                 (exp_data.size() == 0 || (exp_data.size() == 1 && word_ready));
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
`ifdef SPLAT_WRITER_CULL_EN
        chk("cull_count", 64'(cull_count), 64'(m_cull));
`endif
        if (prev_stall) begin
            chk("stall_valid", 64'(word_valid), 64'd1);
            chk("stall_data", word_data, prev_data);
            chk("stall_addr", 64'(word_addr), 64'(prev_addr));
        end
        if (word_valid) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;

        if (reset) begin
            exp_data.delete(); exp_addr.delete(); exp_last.delete();
            m_active = 1'b0; m_written = '0; m_cull = '0; m_n = 0;
            prev_stall = 1'b0;
        end else begin
            if (word_valid && word_ready) begin
                if (exp_data.size() == 0) begin
                    timeout("unexpected_word");
                end else begin
                    chk("word_data", word_data, exp_data[0]);
                    chk("word_addr", 64'(word_addr), 64'(exp_addr[0]));
                    obs_data.push_back(word_data);
                    obs_addr.push_back(word_addr);
                    if (exp_last[0]) m_written = m_written + 1'b1;
                    void'(exp_data.pop_front());
                    void'(exp_addr.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            prev_stall = word_valid && !word_ready && !start;
            prev_data  = word_data;
            prev_addr  = word_addr;
            if (start) begin
                exp_data.delete(); exp_addr.delete(); exp_last.delete();
                m_active = 1'b1; m_base = base_addr; m_n = 0; m_written = '0; m_cull = '0;
            end else if (in_valid && in_ready) begin
                v = cur_vec();
                if (is_culled(v)) begin
                    m_cull = m_cull + 1'b1;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        exp_data.push_back(ref_word(v, k));
                        exp_addr.push_back(m_base + ADDR_W'(4 * m_n + k));
                        exp_last.push_back(k == 3);
                    end
                    m_n++;
                end
            end
        end
    end

    task automatic set_fields(input vec_t v);
        sx_fp = v.sx; sy_fp = v.sy; depth = v.dp; cov_a_fp = v.ca; cov_c_fp = v.cc;
        cov_b2_fp = v.cb2; r = v.cr; g = v.cg; b = v.cb; opacity = v.op;
        bbox_x0 = v.x0; bbox_y0 = v.y0; bbox_x1 = v.x1; bbox_y1 = v.y1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // presents vecs[first..] back to back; rdy_mode=1 drives word_ready 1,0,0,1,0,0...
    task automatic send(input int first, input int n, input bit rdy_mode);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 200) begin
            @(posedge clk); #1;
            set_fields(vecs[(first + acc) % 4]);
            in_valid   = 1'b1;
            word_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (acc < n) timeout("send");
    endtask

    task automatic wait_idle(input bit rdy_mode);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (exp_data.size() == 0 && !word_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
                word_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
            end
            cyc++;
        end
        word_ready = 1'b1;
        if (!done) timeout("wait_idle");
    endtask

    initial begin
        vecs[0] = mk(32'h00000150, 32'hFFFFFFF0, 32'h3F800000, 16'h4000, 16'h2000,
                     32'hFFFFF000, 8'h11, 8'h22, 8'h33, 8'hFF,
                     16'hFFFE, 16'd3, 16'd40, 16'd50,
                     64'hFFFFFFF0_00000150, 64'h2000_4000_3F800000,
                     64'hFF332211_FFFFF000, 64'h0032_0028_0003_FFFE);
        vecs[1] = mk(32'h12345678, 32'h9ABCDEF0, 32'h40490FDB, 16'h1111, 16'h2222,
                     32'h00000ABC, 8'h01, 8'h02, 8'h03, 8'h04,
                     16'h0000, 16'h0001, 16'h0010, 16'h0020,
                     64'h9ABCDEF0_12345678, 64'h2222_1111_40490FDB,
                     64'h04030201_00000ABC, 64'h0020_0010_0001_0000);
        vecs[2] = mk(32'hFFFFFFFF, 32'h00000000, 32'h80000000, 16'hFFFF, 16'h0000,
                     32'h7FFFFFFF, 8'hAA, 8'h55, 8'h00, 8'h80,
                     16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                     64'h00000000_FFFFFFFF, 64'h0000_FFFF_80000000,
                     64'h800055AA_7FFFFFFF, 64'h7FFF_7FFF_7FFF_8000);
        vecs[3] = mk(32'h1, 32'h2, 32'h3, 16'h4, 16'h5, 32'h6, 8'h7, 8'h8, 8'h9, 8'hA,
                     16'd10, 16'd0, 16'd5, 16'd20, 64'h0, 64'h0, 64'h0, 64'h0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // no start yet: input must be refused
        set_fields(vecs[0]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("prestart_in_ready", 64'(in_ready), 64'd0);
            chk("prestart_word_valid", 64'(word_valid), 64'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        // table vectors, one at a time
        do_start(29'h100);
        for (int i = 0; i < 3; i++) begin
            obs_data.delete(); obs_addr.delete();
            send(i, 1, 1'b0);
            wait_idle(1'b0);
            chk("tbl_nwords", 64'(obs_data.size()), 64'd4);
            for (int k = 0; k < 4 && k < obs_data.size(); k++) begin
                chk("tbl_data", obs_data[k], vecs[i].w[k]);
                chk("tbl_addr", 64'(obs_addr[k]), 64'(29'h100 + 4 * i + k));
            end
            chk("tbl_count", 64'(splat_count), 64'(i + 1));
        end

        // three splats back to back: no bubble
        do_start(29'h400);
        obs_data.delete(); obs_addr.delete();
        max_run = 0;
        send(0, 3, 1'b0);
        wait_idle(1'b0);
        chk("burst_run", 64'(max_run), 64'd12);
        chk("burst_nwords", 64'(obs_data.size()), 64'd12);
        for (int k = 0; k < 12 && k < obs_addr.size(); k++)
            chk("burst_addr", 64'(obs_addr[k]), 64'(29'h400 + k));
        chk("burst_count", 64'(splat_count), 64'd3);

        // stalling downstream
        do_start(29'h900);
        obs_data.delete(); obs_addr.delete();
        send(0, 2, 1'b1);
        wait_idle(1'b1);
        chk("stall_nwords", 64'(obs_data.size()), 64'd8);
        for (int k = 0; k < 8 && k < obs_data.size(); k++) begin
            chk("stall_seq_data", obs_data[k], vecs[k / 4].w[k % 4]);
            chk("stall_seq_addr", 64'(obs_addr[k]), 64'(29'h900 + k));
        end

        // start after word 1 abandons the splat
        do_start(29'h500);
        obs_data.delete(); obs_addr.delete();
        send(0, 1, 1'b0);
        for (int i = 0; i < 20 && obs_data.size() < 2; i++) @(negedge clk);
        chk("abort_pre_words", 64'(obs_data.size()), 64'd2);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 29'h600; word_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; word_ready = 1'b1;
        @(negedge clk);
        chk("abort_valid", 64'(word_valid), 64'd0);
        chk("abort_count", 64'(splat_count), 64'd0);
        obs_data.delete(); obs_addr.delete();
        send(1, 1, 1'b0);
        wait_idle(1'b0);
        chk("abort_nwords", 64'(obs_data.size()), 64'd4);
        for (int k = 0; k < 4 && k < obs_data.size(); k++) begin
            chk("abort_data", obs_data[k], vecs[1].w[k]);
            chk("abort_addr", 64'(obs_addr[k]), 64'(29'h600 + k));
        end

        // address wrap
        do_start(29'h1FFFFFFE);
        obs_data.delete(); obs_addr.delete();
        send(0, 2, 1'b0);
        wait_idle(1'b0);
        chk("wrap_nwords", 64'(obs_addr.size()), 64'd8);
        for (int k = 0; k < 8 && k < obs_addr.size(); k++)
            chk("wrap_addr", 64'(obs_addr[k]), 64'((29'h1FFFFFFE + k) & 29'h1FFFFFFF));

`ifdef SPLAT_WRITER_CULL_EN
        do_start(29'h800);
        obs_data.delete(); obs_addr.delete();
        send(3, 1, 1'b0);
        repeat (6) @(negedge clk);
        chk("cull_nwords", 64'(obs_data.size()), 64'd0);
        chk("cull_count_one", 64'(cull_count), 64'd1);
        chk("cull_splat_count", 64'(splat_count), 64'd0);
        send(0, 1, 1'b0);
        wait_idle(1'b0);
        chk("cull_after_addr", 64'(obs_addr.size() > 0 ? obs_addr[0] : '1), 64'(29'h800));
        chk("cull_after_count", 64'(splat_count), 64'd1);
`endif

        // randomized traffic against the model
        do_start(29'(($urandom)));
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid   = $urandom_range(0, 1) == 1;
            word_ready = $urandom_range(0, 3) != 0;
            start      = $urandom_range(0, 199) == 0;
            base_addr  = 29'($urandom);
            sx_fp = $urandom; sy_fp = $urandom; depth = $urandom; cov_b2_fp = $urandom;
            cov_a_fp = 16'($urandom); cov_c_fp = 16'($urandom);
            {r, g, b, opacity} = $urandom;
            bbox_x0 = 16'($urandom); bbox_y0 = 16'($urandom);
            bbox_x1 = 16'($urandom); bbox_y1 = 16'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0; word_ready = 1'b1;
        wait_idle(1'b0);

        // reset in the middle of a splat
        do_start(29'h700);
        send(0, 1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_word_valid", 64'(word_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_count", 64'(splat_count), 64'd0);
            chk("rst_addr", 64'(word_addr), 64'd0);
            chk("rst_data", word_data, 64'd0);
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
